// File: rtl/seq_shift_unit.sv
// Multi-cycle shifter: LSL/LSR/ASR/ROL/ROR, one bit position per clock; optional carry_out via SEQ_SHIFT_CARRY_EN.
// Latency: start at E0 -> done pulse between E(shamt) and E(shamt+1); shamt=0 -> done the cycle after E0.
// Backpressure: none; start is only sampled in IDLE, requests while busy (incl. DONE) are dropped.
module seq_shift_unit #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2:0]         mode,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   din,
    output logic [WIDTH-1:0]   dout,
`ifdef SEQ_SHIFT_CARRY_EN
    output logic               carry_out,
`endif
    output logic               busy,
    output logic               done
);

    localparam logic [2:0] MODE_LSL = 3'b000;
    localparam logic [2:0] MODE_LSR = 3'b001;
    localparam logic [2:0] MODE_ASR = 3'b010;
    localparam logic [2:0] MODE_ROL = 3'b011;
    localparam logic [2:0] MODE_ROR = 3'b100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SHAMT_W-1:0] cnt_q;
    logic [2:0]         mode_q;
    logic [WIDTH-1:0]   step_dat;
    logic               accept;

    assign accept = (state_q == IDLE) && start;
    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (shamt == '0) ? DONE : SHIFT;
            SHIFT:   if (cnt_q == SHAMT_W'(1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Reserved modes hold the data but still burn the counted cycles.
    always_comb begin
        step_dat = dout;
        case (mode_q)
            MODE_LSL: step_dat = {dout[WIDTH-2:0], 1'b0};
            MODE_LSR: step_dat = {1'b0, dout[WIDTH-1:1]};
            MODE_ASR: step_dat = {dout[WIDTH-1], dout[WIDTH-1:1]};
            MODE_ROL: step_dat = {dout[WIDTH-2:0], dout[WIDTH-1]};
            MODE_ROR: step_dat = {dout[0], dout[WIDTH-1:1]};
            default:  step_dat = dout;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout   <= '0;
            cnt_q  <= '0;
            mode_q <= '0;
        end else if (accept) begin
            dout   <= din;
            cnt_q  <= shamt;
            mode_q <= mode;
        end else if (state_q == SHIFT) begin
            dout   <= step_dat;
            cnt_q  <= cnt_q - 1'b1;
        end
    end

`ifdef SEQ_SHIFT_CARRY_EN
    logic out_bit;

    always_comb begin
        out_bit = 1'b0;
        case (mode_q)
            MODE_LSL, MODE_ROL:           out_bit = dout[WIDTH-1];
            MODE_LSR, MODE_ASR, MODE_ROR: out_bit = dout[0];
            default:                      out_bit = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  carry_out <= 1'b0;
        else if (accept)             carry_out <= 1'b0;
        else if (state_q == SHIFT)   carry_out <= out_bit;
    end
`endif

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed-vector bench for seq_shift_unit: results, done latency, busy, ignored starts, mid-op reset.
module tb_seq_shift_unit;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] mode;
    logic [2:0] shamt;
    logic [7:0] din;
    logic [7:0] dout;
    logic       busy;
    logic       done;
`ifdef SEQ_SHIFT_CARRY_EN
    logic       carry_out;
`endif

    int n_chk;
    int n_pass;

    seq_shift_unit #(.WIDTH(8), .SHAMT_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .shamt     (shamt),
        .din       (din),
        .dout      (dout),
`ifdef SEQ_SHIFT_CARRY_EN
        .carry_out (carry_out),
`endif
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // poke keeps start asserted with junk operands through SHIFT and DONE.
    task automatic run_op(input string tag, input logic [2:0] m, input logic [2:0] s,
                          input logic [7:0] d, input logic [7:0] exp_dout,
                          input logic exp_c, input logic poke);
        int n;
        @(negedge clk);
        mode = m; shamt = s; din = d; start = 1'b1;
        @(posedge clk); #1;
        start = poke; din = 8'hFF; mode = 3'b100; shamt = 3'd1;
        if (s != 3'd0) begin
            check({tag, ".busy_e0"}, {31'd0, busy}, 32'd1);
            check({tag, ".done_e0"}, {31'd0, done}, 32'd0);
        end
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, ".latency"}, n, {29'd0, s});
        check({tag, ".dout"}, {24'd0, dout}, {24'd0, exp_dout});
        check({tag, ".busy_done"}, {31'd0, busy}, 32'd1);
`ifdef SEQ_SHIFT_CARRY_EN
        check({tag, ".carry"}, {31'd0, carry_out}, {31'd0, exp_c});
`endif
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, ".done_clr"}, {31'd0, done}, 32'd0);
        check({tag, ".idle"}, {31'd0, busy}, 32'd0);
        check({tag, ".dout_hold"}, {24'd0, dout}, {24'd0, exp_dout});
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        rst_n = 1'b0; start = 1'b0; mode = 3'd0; shamt = 3'd0; din = 8'd0;
        #3;
        check("rst.dout", {24'd0, dout}, 32'd0);
        check("rst.busy", {31'd0, busy}, 32'd0);
        check("rst.done", {31'd0, done}, 32'd0);
`ifdef SEQ_SHIFT_CARRY_EN
        check("rst.carry", {31'd0, carry_out}, 32'd0);
`endif
        #9 rst_n = 1'b1;

        run_op("lsl",   3'b000, 3'd3, 8'hB1, 8'h88, 1'b1, 1'b0);
        run_op("lsr",   3'b001, 3'd3, 8'hB1, 8'h16, 1'b0, 1'b0);
        run_op("asr",   3'b010, 3'd3, 8'hB1, 8'hF6, 1'b0, 1'b0);
        run_op("rol",   3'b011, 3'd3, 8'hB1, 8'h8D, 1'b1, 1'b0);
        run_op("ror",   3'b100, 3'd3, 8'hB1, 8'h36, 1'b0, 1'b0);
        run_op("rol7",  3'b011, 3'd7, 8'h81, 8'hC0, 1'b0, 1'b0);
        run_op("lsr7",  3'b001, 3'd7, 8'hFF, 8'h01, 1'b1, 1'b0);
        run_op("asr7",  3'b010, 3'd7, 8'h80, 8'hFF, 1'b0, 1'b0);
        run_op("rsvd",  3'b101, 3'd2, 8'h3C, 8'h3C, 1'b0, 1'b0);
        run_op("zero",  3'b000, 3'd0, 8'h5A, 8'h5A, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("idle3.dout", {24'd0, dout}, 32'h5A);
        check("idle3.done", {31'd0, done}, 32'd0);

        run_op("poke",  3'b000, 3'd3, 8'hB1, 8'h88, 1'b1, 1'b1);
        run_op("after", 3'b100, 3'd1, 8'h03, 8'h81, 1'b1, 1'b0);

        @(negedge clk);
        mode = 3'b000; shamt = 3'd5; din = 8'hB1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        check("mrst.dout", {24'd0, dout}, 32'd0);
        check("mrst.busy", {31'd0, busy}, 32'd0);
        check("mrst.done", {31'd0, done}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        run_op("fresh", 3'b000, 3'd2, 8'h01, 8'h04, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
